// File: rtl/tcp_checksum_stream.sv
// ============================================================================
// Module  : tcp_checksum_stream
// Purpose : Streaming Internet (ones-complement) checksum engine. Packets
//           arrive on an AXI4-Stream, and each packet has one {offset, seed}
//           descriptor. The engine emits the 16-bit complemented checksum on
//           a result stream. A small result FIFO, guarded by a credit
//           counter, lets packet intake continue under output backpressure.
// Ports   : clk, rst_n                 - clock, async active-low reset
//           S_AXIS_TDATA/TKEEP/TVALID/TLAST/TREADY - packet data stream
//           S_SEED_TDATA/TVALID/TREADY - descriptor {offset[31:16], seed[15:0]}
//           M_AXIS_TDATA/TVALID/TREADY - complemented checksum result
//           M_AXIS_TUSER               - checksum-verifies flag (optional)
// Options : TCP_CKSUM_VERIFY_EN - adds M_AXIS_TUSER, stored with each result
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tcp_checksum_stream #(
  parameter int DATA_WIDTH = 512,
  parameter int OUT_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXIS_TKEEP,
  input  logic                    S_AXIS_TVALID,
  input  logic                    S_AXIS_TLAST,
  output logic                    S_AXIS_TREADY,
  input  logic [31:0]             S_SEED_TDATA,
  input  logic                    S_SEED_TVALID,
  output logic                    S_SEED_TREADY,
  output logic [15:0]             M_AXIS_TDATA,
  output logic                    M_AXIS_TVALID,
  input  logic                    M_AXIS_TREADY
`ifdef TCP_CKSUM_VERIFY_EN
  ,
  output logic                    M_AXIS_TUSER
`endif
);

  localparam int C_BYTES = DATA_WIDTH / 8;
  localparam int C_WORDS = DATA_WIDTH / 16;
  localparam int C_AW    = $clog2(OUT_DEPTH);
`ifdef TCP_CKSUM_VERIFY_EN
  localparam int C_FW    = 17;
`else
  localparam int C_FW    = 16;
`endif
  localparam logic [15:0]   C_BEAT_BYTES = 16'(C_BYTES);
  localparam logic [C_AW:0] C_DEPTH      = (C_AW + 1)'(OUT_DEPTH);

  // --------------------------------------------------------------------------
  // Intake control
  // --------------------------------------------------------------------------
  logic                  r_active;   // low in reset; keeps both readies at 0
  logic                  r_start;    // next accepted beat opens a packet
  logic [C_AW:0]         r_credit;   // results in flight plus results stored
  logic [15:0]           r_byte_idx; // packet byte index of the next beat
  logic [15:0]           r_offset;   // header offset of the current packet

  logic                  w_credit_ok;
  logic                  w_beat;
  logic                  w_fifo_rd;
  logic [15:0]           w_base;
  logic [15:0]           w_offset;
  logic [DATA_WIDTH-1:0] w_masked;

  assign w_credit_ok   = r_credit < C_DEPTH;
  assign S_AXIS_TREADY = r_active & w_credit_ok & (~r_start | S_SEED_TVALID);
  assign S_SEED_TREADY = r_active & r_start & S_AXIS_TVALID & w_credit_ok;
  assign w_beat        = S_AXIS_TVALID & S_AXIS_TREADY;
  assign w_fifo_rd     = M_AXIS_TVALID & M_AXIS_TREADY;

  // On the first beat the descriptor is live on S_SEED_TDATA and the index
  // restarts at zero; later beats use the latched offset and running index.
  assign w_base   = r_start ? 16'd0 : r_byte_idx;
  assign w_offset = r_start ? S_SEED_TDATA[31:16] : r_offset;

  always_comb begin
    w_masked = '0;
    for (int i = 0; i < C_BYTES; i++) begin
      if (S_AXIS_TKEEP[i] && ((w_base + 16'(i)) >= w_offset)) begin
        w_masked[8*i +: 8] = S_AXIS_TDATA[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active   <= 1'b0;
      r_start    <= 1'b1;
      r_credit   <= '0;
      r_byte_idx <= '0;
      r_offset   <= '0;
    end else begin
      r_active <= 1'b1;
      if (w_beat) begin
        r_start    <= S_AXIS_TLAST;
        r_byte_idx <= w_base + C_BEAT_BYTES;
        r_offset   <= w_offset;
      end
      case ({w_beat & S_AXIS_TLAST, w_fifo_rd})
        2'b10:   r_credit <= r_credit + (C_AW + 1)'(1);
        2'b01:   r_credit <= r_credit - (C_AW + 1)'(1);
        default: r_credit <= r_credit;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Stage 0: masked data and control
  // --------------------------------------------------------------------------
  logic                  r_s0_valid, r_s0_last, r_s0_first;
  logic [DATA_WIDTH-1:0] r_s0_data;
  logic [15:0]           r_s0_seed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0_valid <= 1'b0;
      r_s0_last  <= 1'b0;
      r_s0_first <= 1'b0;
      r_s0_data  <= '0;
      r_s0_seed  <= '0;
    end else begin
      r_s0_valid <= w_beat;
      if (w_beat) begin
        r_s0_last  <= S_AXIS_TLAST;
        r_s0_first <= r_start;
        r_s0_data  <= w_masked;
        r_s0_seed  <= S_SEED_TDATA[15:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: sum of all 16-bit network-order words of the beat
  // --------------------------------------------------------------------------
  logic [31:0] w_tree;
  logic        r_s1_valid, r_s1_last, r_s1_first;
  logic [31:0] r_s1_sum;
  logic [15:0] r_s1_seed;

  always_comb begin
    w_tree = '0;
    for (int k = 0; k < C_WORDS; k++) begin
      // byte 2k is the high byte of word k
      w_tree = w_tree + {16'd0, r_s0_data[16*k +: 8], r_s0_data[16*k+8 +: 8]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_sum   <= '0;
      r_s1_seed  <= '0;
    end else begin
      r_s1_valid <= r_s0_valid;
      if (r_s0_valid) begin
        r_s1_last  <= r_s0_last;
        r_s1_first <= r_s0_first;
        r_s1_sum   <= w_tree;
        r_s1_seed  <= r_s0_seed;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: fold to 16 bits and accumulate with end-around carry
  // --------------------------------------------------------------------------
  logic [15:0] r_acc;
  logic [16:0] w_f1;
  logic [15:0] w_f2;
  logic [15:0] w_acc_in;
  logic [16:0] w_t;
  logic [15:0] w_sum;
  logic        w_fifo_wr;
  logic [C_FW-1:0] w_wr_data;

  // The first fold leaves at most one carry, and the second fold absorbs it
  // without overflow. The seed replaces the running sum on a packet's first
  // beat, so back-to-back packets need no idle cycle.
  assign w_f1      = {1'b0, r_s1_sum[15:0]} + {1'b0, r_s1_sum[31:16]};
  assign w_f2      = w_f1[15:0] + {15'd0, w_f1[16]};
  assign w_acc_in  = r_s1_first ? r_s1_seed : r_acc;
  assign w_t       = {1'b0, w_acc_in} + {1'b0, w_f2};
  assign w_sum     = w_t[15:0] + {15'd0, w_t[16]};
  assign w_fifo_wr = r_s1_valid & r_s1_last;

`ifdef TCP_CKSUM_VERIFY_EN
  assign w_wr_data = {(w_sum == 16'hFFFF), ~w_sum};
`else
  assign w_wr_data = ~w_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (r_s1_valid) begin
      r_acc <= r_s1_last ? 16'd0 : w_sum;
    end
  end

  // --------------------------------------------------------------------------
  // Result FIFO; the credit counter guarantees it never overflows
  // --------------------------------------------------------------------------
  logic [C_FW-1:0] r_mem [OUT_DEPTH];
  logic [C_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [C_AW:0]   r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUT_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_fifo_wr) begin
        r_mem[r_wr_ptr] <= w_wr_data;
        r_wr_ptr        <= r_wr_ptr + C_AW'(1);
      end
      if (w_fifo_rd) begin
        r_rd_ptr <= r_rd_ptr + C_AW'(1);
      end
      case ({w_fifo_wr, w_fifo_rd})
        2'b10:   r_count <= r_count + (C_AW + 1)'(1);
        2'b01:   r_count <= r_count - (C_AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign M_AXIS_TVALID = (r_count != '0);
  assign M_AXIS_TDATA  = r_mem[r_rd_ptr][15:0];
`ifdef TCP_CKSUM_VERIFY_EN
  assign M_AXIS_TUSER  = r_mem[r_rd_ptr][16];
`endif

endmodule

`default_nettype wire

// File: tb/tb_tcp_checksum_stream.sv
// ============================================================================
// Module  : tb_tcp_checksum_stream
// Purpose : Self-checking bench for tcp_checksum_stream (64-bit bus, depth 2).
//           The stimulus side pushes expected results into a scoreboard queue
//           and a separate monitor pops and compares on every result
//           handshake. Random packets are checked against a byte-level
//           ones-complement reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tcp_checksum_stream;

  localparam int DW = 64;
  localparam int OD = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] S_AXIS_TDATA;
  logic [DW/8-1:0] S_AXIS_TKEEP;
  logic          S_AXIS_TVALID;
  logic          S_AXIS_TLAST;
  logic          S_AXIS_TREADY;
  logic [31:0]   S_SEED_TDATA;
  logic          S_SEED_TVALID;
  logic          S_SEED_TREADY;
  logic [15:0]   M_AXIS_TDATA;
  logic          M_AXIS_TVALID;
  logic          M_AXIS_TREADY;
`ifdef TCP_CKSUM_VERIFY_EN
  logic          M_AXIS_TUSER;
`endif

  tcp_checksum_stream #(.DATA_WIDTH(DW), .OUT_DEPTH(OD)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TKEEP  (S_AXIS_TKEEP),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .S_AXIS_TLAST  (S_AXIS_TLAST),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .S_SEED_TDATA  (S_SEED_TDATA),
    .S_SEED_TVALID (S_SEED_TVALID),
    .S_SEED_TREADY (S_SEED_TREADY),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY)
`ifdef TCP_CKSUM_VERIFY_EN
    ,
    .M_AXIS_TUSER  (M_AXIS_TUSER)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [16:0] sb [$];          // {tuser, checksum}
  logic        tready_cmd = 1'b1;
  logic        rand_mode  = 1'b0;

  logic [7:0]  pkt [0:63];
  int          pkt_len, pkt_off, pkt_seed;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: ones-complement sum over network-order words of the packet
  // bytes, bytes before the offset treated as zero, odd tail padded with 0.
  function automatic logic [16:0] model_cksum();
    int acc;
    int w;
    logic [15:0] a16;
    acc = pkt_seed;
    for (int k = 0; k < pkt_len; k += 2) begin
      w = 0;
      if (k >= pkt_off) w += int'(pkt[k]) * 256;
      if ((k + 1 < pkt_len) && (k + 1 >= pkt_off)) w += int'(pkt[k+1]);
      acc += w;
      if (acc > 65535) acc -= 65535;
    end
    a16 = acc[15:0];
    return {(a16 == 16'hFFFF), ~a16};
  endfunction

  // Owns M_AXIS_TREADY; updates at posedge+2 so commands set at posedge+1
  // take effect in the same cycle.
  initial begin
    M_AXIS_TREADY = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (rand_mode) M_AXIS_TREADY = ($urandom_range(0, 3) != 0);
      else           M_AXIS_TREADY = tready_cmd;
    end
  end

  // Monitor: pops the scoreboard on each result handshake, and checks that a
  // stalled result stays unchanged.
  initial begin
    logic        stall_prev;
    logic [15:0] prev_data;
    logic [16:0] exp;
    stall_prev = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) chk("hold_stable", {15'd0, M_AXIS_TVALID, M_AXIS_TDATA}, {15'd0, 1'b1, prev_data});
        if (M_AXIS_TVALID && M_AXIS_TREADY) begin
          if (sb.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
          end else begin
            exp = sb.pop_front();
`ifdef TCP_CKSUM_VERIFY_EN
            chk("result", {15'd0, M_AXIS_TUSER, M_AXIS_TDATA}, {15'd0, exp});
`else
            chk("result", {16'd0, M_AXIS_TDATA}, {16'd0, exp[15:0]});
`endif
          end
        end
        stall_prev = M_AXIS_TVALID && !M_AXIS_TREADY;
        prev_data  = M_AXIS_TDATA;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic drive_beat(input logic [DW-1:0] d, input logic [DW/8-1:0] k,
                            input logic last, input logic first, input logic [31:0] sd);
    int n;
    S_AXIS_TDATA  = d;
    S_AXIS_TKEEP  = k;
    S_AXIS_TLAST  = last;
    S_AXIS_TVALID = 1'b1;
    S_SEED_TDATA  = first ? sd : $urandom;
    S_SEED_TVALID = first;
    n = 0;
    forever begin
      @(negedge clk);
      if (S_AXIS_TREADY) break;
      n++;
      if (n > 1000) begin
        chk("beat_accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    if (first) chk("seed_taken_with_first_beat", {31'd0, S_SEED_TREADY}, 32'd1);
    @(posedge clk);
    #1;
    S_AXIS_TVALID = 1'b0;
    S_SEED_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
  endtask

  task automatic send_packet(input logic [16:0] exp, input bit gaps);
    int nb, idx, g;
    logic [DW-1:0]   d;
    logic [DW/8-1:0] k;
    sb.push_back(exp);
    nb = (pkt_len == 0) ? 1 : (pkt_len + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < 8; j++) begin
        idx = b * 8 + j;
        if (idx < pkt_len) begin
          d[8*j +: 8] = pkt[idx];
          k[j] = 1'b1;
        end else begin
          d[8*j +: 8] = 8'($urandom);
          k[j] = 1'b0;
        end
      end
      drive_beat(d, k, (b == nb - 1), (b == 0), {pkt_off[15:0], pkt_seed[15:0]});
      if (gaps) begin
        g = $urandom_range(0, 2);
        repeat (g) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic set8(input logic [63:0] bytes_msb_first, input int len, input int off, input int seed);
    for (int i = 0; i < 8; i++) pkt[i] = bytes_msb_first[63 - 8*i -: 8];
    pkt_len  = len;
    pkt_off  = off;
    pkt_seed = seed;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    S_AXIS_TDATA  = '0;
    S_AXIS_TKEEP  = '0;
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
    S_SEED_TDATA  = '0;
    S_SEED_TVALID = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_m_tvalid", {31'd0, M_AXIS_TVALID}, 32'd0);
    chk("rst_m_tdata",  {16'd0, M_AXIS_TDATA},  32'd0);
    chk("rst_s_tready", {31'd0, S_AXIS_TREADY}, 32'd0);
    chk("rst_seed_tready", {31'd0, S_SEED_TREADY}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // IPv4-header-like beat; result must appear exactly 3 cycles later
    set8(64'h4500_0073_0000_4000, 8, 0, 0);
    sb.push_back({1'b0, 16'h7A8C});
    drive_beat({pkt[7], pkt[6], pkt[5], pkt[4], pkt[3], pkt[2], pkt[1], pkt[0]},
               8'hFF, 1'b1, 1'b1, 32'd0);
    @(negedge clk); chk("latency_t1", {31'd0, M_AXIS_TVALID}, 32'd0);
    @(negedge clk); chk("latency_t2", {31'd0, M_AXIS_TVALID}, 32'd0);
    @(negedge clk); chk("latency_t3", {31'd0, M_AXIS_TVALID}, 32'd1);
    chk("latency_data", {16'd0, M_AXIS_TDATA}, 32'h7A8C);
    @(posedge clk); #1;

    // Odd length, carry wrap, zero-length contribution
    set8(64'h0102_0300_0000_0000, 3, 0, 0);
    send_packet({1'b0, 16'hFBFD}, 1'b0);
    set8(64'hFFFF_0000_0000_0000, 4, 0, 16'h0001);
    send_packet({1'b0, 16'hFFFE}, 1'b0);
    pkt_len = 0; pkt_off = 0; pkt_seed = 16'h1234;
    send_packet({1'b0, 16'hEDCB}, 1'b0);

    // Offset with the descriptor presented early
    set8(64'hAABB_CCDD_1234_5678, 8, 4, 0);
    S_SEED_TDATA  = {16'd4, 16'd0};
    S_SEED_TVALID = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("seed_held_without_data", {31'd0, S_SEED_TREADY}, 32'd0);
    end
    @(posedge clk); #1;
    send_packet({1'b0, 16'h9753}, 1'b0);

    // Verify-style packets: valid header and one corrupted byte
    set8(64'h4500_0073_7A8C_4000, 8, 0, 0);
    send_packet({1'b1, 16'h0000}, 1'b0);
    set8(64'h4600_0073_7A8C_4000, 8, 0, 0);
    send_packet({1'b0, 16'hFEFF}, 1'b0);
    wait_drain();

    // Backpressure: two results fill the credits, the third beat stalls
    tready_cmd = 1'b0;
    @(posedge clk); #1;
    set8(64'h1111_2222_3333_4444, 8, 0, 16'h0101);
    send_packet(model_cksum(), 1'b0);
    set8(64'h5555_6666_7777_8888, 8, 0, 16'h0202);
    send_packet(model_cksum(), 1'b0);
    set8(64'h9999_AAAA_BBBB_CCCC, 8, 0, 16'h0303);
    sb.push_back(model_cksum());
    S_AXIS_TDATA  = {pkt[7], pkt[6], pkt[5], pkt[4], pkt[3], pkt[2], pkt[1], pkt[0]};
    S_AXIS_TKEEP  = 8'hFF;
    S_AXIS_TLAST  = 1'b1;
    S_AXIS_TVALID = 1'b1;
    S_SEED_TDATA  = 32'h0000_0303;
    S_SEED_TVALID = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("stall_s_tready", {31'd0, S_AXIS_TREADY}, 32'd0);
    end
    @(posedge clk); #1; tready_cmd = 1'b1;
    @(posedge clk); #1; tready_cmd = 1'b0;
    drive_beat(S_AXIS_TDATA, 8'hFF, 1'b1, 1'b1, 32'h0000_0303);
    tready_cmd = 1'b1;
    wait_drain();

    // Reset in the middle of a packet with a result waiting in the FIFO
    tready_cmd = 1'b0;
    @(posedge clk); #1;
    set8(64'h0F0F_F0F0_1234_ABCD, 8, 0, 16'h4321);
    send_packet(model_cksum(), 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    drive_beat(64'hDEAD_BEEF_0123_4567, 8'hFF, 1'b0, 1'b1, 32'h0000_1111);
    S_AXIS_TVALID = 1'b1;
    S_SEED_TVALID = 1'b1;
    @(negedge clk);
    chk("pre_reset_m_tvalid", {31'd0, M_AXIS_TVALID}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_m_tvalid", {31'd0, M_AXIS_TVALID}, 32'd0);
    chk("midrst_s_tready", {31'd0, S_AXIS_TREADY}, 32'd0);
    chk("midrst_seed_tready", {31'd0, S_SEED_TREADY}, 32'd0);
    sb.delete();
    S_AXIS_TVALID = 1'b0;
    S_SEED_TVALID = 1'b0;
    tready_cmd    = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Random packets under random output backpressure
    rand_mode = 1'b1;
    for (int p = 0; p < 60; p++) begin
      pkt_len  = $urandom_range(0, 40);
      pkt_off  = 2 * $urandom_range(0, 12);
      pkt_seed = $urandom_range(0, 65535);
      for (int i = 0; i < 64; i++) pkt[i] = 8'($urandom);
      send_packet(model_cksum(), 1'b1);
    end
    rand_mode = 1'b0;
    wait_drain();
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
